// File: rtl/lsu_mem_ctrl_if.sv
// Request, result and data-bus signals of the load/store unit.
// slave is the unit itself; master is the execute/write-back/bus side.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              ren;
    logic              wen;
    logic [2:0]        mem_op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              out_valid;
    logic [31:0]       out_rdata;
    logic              out_err;
    logic              bus_valid;
    logic              bus_ready;
    logic              bus_wen;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wmask;
    logic              bus_resp_valid;
    logic [31:0]       bus_rdata;

    modport slave (
        input  in_valid, ren, wen, mem_op, addr, wdata,
        input  bus_ready, bus_resp_valid, bus_rdata,
        output in_ready, out_valid, out_rdata, out_err,
        output bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask
    );

    modport master (
        output in_valid, ren, wen, mem_op, addr, wdata,
        output bus_ready, bus_resp_valid, bus_rdata,
        input  in_ready, out_valid, out_rdata, out_err,
        input  bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one word-aligned bus access per request,
// store lane alignment and load extraction, one-cycle result pulse.
module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    lsu_mem_ctrl_if.slave io
);
    typedef enum logic [1:0] {
        S_IDLE, S_REQ, S_WAIT, S_DONE
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TMO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TMO_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            r_state;
    logic [2:0]        r_op;
    logic [1:0]        r_off;
    logic              r_wr;
    logic [CW-1:0]     r_cnt;
    logic              r_out_valid;
    logic              r_out_err;
    logic [31:0]       r_out_rdata;
    logic              r_bus_valid;
    logic              r_bus_wen;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [3:0]        r_bus_wmask;

    logic        w_accept;
    logic        w_ld_ok;
    logic        w_st_ok;
    logic        w_mis;
    logic        w_err;
    logic        w_nomem;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_ldata;

    assign io.in_ready  = (r_state == S_IDLE);
    assign io.out_valid = r_out_valid;
    assign io.out_err   = r_out_err;
    assign io.out_rdata = r_out_rdata;
    assign io.bus_valid = r_bus_valid;
    assign io.bus_wen   = r_bus_wen;
    assign io.bus_addr  = r_bus_addr;
    assign io.bus_wdata = r_bus_wdata;
    assign io.bus_wmask = r_bus_wmask;

    assign w_accept = io.in_valid & io.in_ready;
    assign w_nomem  = ~io.ren & ~io.wen;

    assign w_ld_ok = (io.mem_op == 3'b000) | (io.mem_op == 3'b001)
                   | (io.mem_op == 3'b010) | (io.mem_op == 3'b100)
                   | (io.mem_op == 3'b101);
    assign w_st_ok = (io.mem_op == 3'b000) | (io.mem_op == 3'b001)
                   | (io.mem_op == 3'b010);
    assign w_mis = ((io.mem_op[1:0] == 2'b01) & io.addr[0])
                 | ((io.mem_op[1:0] == 2'b10) & (io.addr[1:0] != 2'b00));
    assign w_err = (io.ren & io.wen) | (io.ren & ~w_ld_ok)
                 | (io.wen & ~w_st_ok) | (~w_nomem & w_mis);

    // Store lane placement: replicate the datum and enable its bytes.
    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = 32'h0;
        unique case (io.mem_op[1:0])
            2'b00: begin
                w_wmask = 4'b0001 << io.addr[1:0];
                w_wdata = {4{io.wdata[7:0]}};
            end
            2'b01: begin
                w_wmask = io.addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{io.wdata[15:0]}};
            end
            2'b10: begin
                w_wmask = 4'b1111;
                w_wdata = io.wdata;
            end
            default: begin
                w_wmask = 4'b0000;
                w_wdata = 32'h0;
            end
        endcase
    end

    assign w_shift = io.bus_rdata >> {r_off, 3'b000};

    // Load extraction from the lane-shifted read word.
    always_comb begin
        w_ldata = w_shift;
        unique case (r_op)
            3'b000:  w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ldata = {24'h0, w_shift[7:0]};
            3'b101:  w_ldata = {16'h0, w_shift[15:0]};
            default: w_ldata = w_shift;
        endcase
    end

    // Request FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b000;
            r_off       <= 2'b00;
            r_wr        <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_out_rdata <= 32'h0;
            r_bus_valid <= 1'b0;
            r_bus_wen   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= 32'h0;
            r_bus_wmask <= 4'b0000;
        end else begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= io.mem_op;
                        r_off <= io.addr[1:0];
                        r_wr  <= io.wen;
                        if (w_err | w_nomem) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_out_err   <= w_err;
                            r_out_rdata <= 32'h0;
                        end else begin
                            r_state     <= S_REQ;
                            r_bus_valid <= 1'b1;
                            r_bus_wen   <= io.wen;
                            r_bus_addr  <= {io.addr[ADDR_W-1:2], 2'b00};
                            r_bus_wdata <= io.wen ? w_wdata : 32'h0;
                            r_bus_wmask <= io.wen ? w_wmask : 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    if (io.bus_ready) begin
                        r_bus_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (io.bus_resp_valid) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_rdata <= r_wr ? 32'h0 : w_ldata;
                    end else if (TMO_EN && (r_cnt == TMO_LAST)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_err   <= 1'b1;
                        r_out_rdata <= 32'h0;
                    end else if (TMO_EN) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
